alu_wrap: RTL and testbench

ALU_WRAP -- requirements
Module: alu_wrap

---
 rtl/alu_wrap.sv | 194 +++++++++++++++++++
 tb/tb_alu_wrap.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wrap.sv
// alu_wrap: UART 8N1 packet engine doing echo and 32-bit add (multiply with ALU_WRAP_MUL_EN).
// Bit period is Prescale*8 clk_i cycles for both directions; a 4-entry FIFO feeds the transmitter.
module alu_ctrl (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_full,
    input  logic       i_idle,
    output logic       o_push,
    output logic [7:0] o_data
);
    typedef enum logic [2:0] {IDLE, RSVD, LEN_LO, LEN_HI, ECHO, OPER_A, OPER_B, RESULT} state_t;
    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'hAE;
    state_t      r_state, w_next;
    logic [31:0] operand_a_q, operand_b_q, w_res;
    logic [7:0]  r_op;
    logic [15:0] r_len, w_len;
    logic [2:0]  r_idx;
    logic        w_op_ok;
    assign w_len = {i_data, r_len[7:0]};
`ifdef ALU_WRAP_MUL_EN
    assign w_op_ok = (i_data == OP_ECHO) || (i_data == OP_ADD) || (i_data == OP_MUL);
    assign w_res   = (r_op == OP_MUL) ? operand_a_q * operand_b_q : operand_a_q + operand_b_q;
`else
    assign w_op_ok = (i_data == OP_ECHO) || (i_data == OP_ADD);
    assign w_res   = operand_a_q + operand_b_q;
`endif
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_next;
    end
    // RESULT holds until the last result byte has left the line so late bytes are dropped
    always_comb begin
        w_next = r_state;
        o_push = 1'b0;
        o_data = i_data;
        case (r_state)
            IDLE:   if (i_valid && w_op_ok) w_next = RSVD;
            RSVD:   if (i_valid) w_next = LEN_LO;
            LEN_LO: if (i_valid) w_next = LEN_HI;
            LEN_HI: if (i_valid) w_next = (r_op != OP_ECHO) ? OPER_A : (w_len > 16'd4) ? ECHO : IDLE;
            ECHO: begin
                o_push = i_valid && !i_full;
                if (i_valid && r_len == 16'd1) w_next = IDLE;
            end
            OPER_A: if (i_valid && r_idx[1:0] == 2'd3) w_next = OPER_B;
            OPER_B: if (i_valid && r_idx[1:0] == 2'd3) w_next = RESULT;
            RESULT: begin
                o_push = !r_idx[2] && !i_full;
                o_data = w_res[{r_idx[1:0], 3'b000} +: 8];
                if (r_idx[2] && i_idle) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_op        <= 8'd0;
            r_len       <= 16'd0;
            r_idx       <= 3'd0;
            operand_a_q <= 32'd0;
            operand_b_q <= 32'd0;
        end else begin
            if (r_state == IDLE && i_valid) r_op <= i_data;
            if (r_state == LEN_LO && i_valid) r_len[7:0] <= i_data;
            if (r_state == LEN_HI && i_valid) begin
                r_len <= w_len - 16'd4;
                r_idx <= 3'd0;
            end
            if (r_state == ECHO && i_valid) r_len <= r_len - 16'd1;
            if (r_state == OPER_A && i_valid) begin
                operand_a_q[{r_idx[1:0], 3'b000} +: 8] <= i_data;
                r_idx <= r_idx + 3'd1;
            end
            if (r_state == OPER_B && i_valid) begin
                operand_b_q[{r_idx[1:0], 3'b000} +: 8] <= i_data;
                r_idx <= r_idx + 3'd1;
            end
            if (r_state == RESULT && o_push) r_idx <= r_idx + 3'd1;
        end
    end
endmodule

module alu_wrap #(
    parameter logic [15:0] Prescale = 16'(25125000/(115200*8))
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rx_data_i,
    output logic tx_data_o
);
    localparam logic [18:0] BIT_CYC  = {Prescale, 3'b000};
    localparam logic [18:0] HALF_CYC = {1'b0, Prescale, 2'b00};
    logic [1:0]  r_sync;
    logic        r_rx_prev, r_rx_busy, r_rx_valid;
    logic [3:0]  r_rx_bit;
    logic [18:0] r_rx_cnt;
    logic [7:0]  r_rx_sh;
    logic        w_rx;
    logic [7:0]  r_mem [4];
    logic [2:0]  r_wp, r_rp;
    logic        w_empty, w_full, w_push, w_load;
    logic [7:0]  w_push_data;
    logic [9:0]  r_tx_sh;
    logic        r_tx_busy;
    logic [3:0]  r_tx_bit;
    logic [18:0] r_tx_cnt;
    assign w_rx    = r_sync[1];
    assign w_empty = r_wp == r_rp;
    assign w_full  = (r_wp[1:0] == r_rp[1:0]) && (r_wp[2] != r_rp[2]);
    assign w_load  = !w_empty && !r_tx_busy;
    assign tx_data_o = r_tx_busy ? r_tx_sh[0] : 1'b1;
    // Start needs a falling edge so a low line after a bad stop bit is not taken as a new frame
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sync     <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_bit   <= 4'd0;
            r_rx_cnt   <= 19'd0;
            r_rx_sh    <= 8'd0;
        end else begin
            r_sync     <= {r_sync[0], rx_data_i};
            r_rx_prev  <= w_rx;
            r_rx_valid <= 1'b0;
            if (!r_rx_busy) begin
                if (r_rx_prev && !w_rx) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= HALF_CYC - 19'd1;
                    r_rx_bit  <= 4'd0;
                end
            end else if (r_rx_cnt != 19'd0) begin
                r_rx_cnt <= r_rx_cnt - 19'd1;
            end else begin
                r_rx_cnt <= BIT_CYC - 19'd1;
                r_rx_bit <= r_rx_bit + 4'd1;
                if (r_rx_bit == 4'd0 && w_rx) begin
                    r_rx_busy <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy  <= 1'b0;
                    r_rx_valid <= w_rx;
                end else if (r_rx_bit != 4'd0) begin
                    r_rx_sh <= {w_rx, r_rx_sh[7:1]};
                end
            end
        end
    end
    alu_ctrl ua_inst (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_valid (r_rx_valid),
        .i_data  (r_rx_sh),
        .i_full  (w_full),
        .i_idle  (w_empty && !r_tx_busy),
        .o_push  (w_push),
        .o_data  (w_push_data)
    );
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp[1:0]] <= w_push_data;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wp      <= 3'd0;
            r_rp      <= 3'd0;
            r_tx_sh   <= 10'h3FF;
            r_tx_busy <= 1'b0;
            r_tx_bit  <= 4'd0;
            r_tx_cnt  <= 19'd0;
        end else begin
            if (w_push) r_wp <= r_wp + 3'd1;
            if (w_load) begin
                r_rp      <= r_rp + 3'd1;
                r_tx_sh   <= {1'b1, r_mem[r_rp[1:0]], 1'b0};
                r_tx_busy <= 1'b1;
                r_tx_bit  <= 4'd0;
                r_tx_cnt  <= BIT_CYC - 19'd1;
            end else if (r_tx_busy) begin
                if (r_tx_cnt != 19'd0) begin
                    r_tx_cnt <= r_tx_cnt - 19'd1;
                end else if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                    r_tx_bit <= r_tx_bit + 4'd1;
                    r_tx_cnt <= BIT_CYC - 19'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_wrap.sv
// tb_alu_wrap: drives UART packets into alu_wrap and compares the decoded TX stream
// against a packet-level reference model; honours ALU_WRAP_MUL_EN.
module tb_alu_wrap;
    localparam int P    = 2;
    localparam int BITC = P * 8;
`ifdef ALU_WRAP_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic tx;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] got[$];
    logic [7:0] stim[$];
    logic [7:0] exp_q[$];
    time lat[$];
    time last_mid = 0;
    bit aborted = 1'b0;

    always #5 clk = ~clk;

    alu_wrap #(.Prescale(16'(P))) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .rx_data_i (rx),
        .tx_data_o (tx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    always @(posedge rst) aborted = 1'b1;

    initial begin : monitor
        logic [7:0] b;
        time t0;
        forever begin
            @(negedge tx);
            if (!rst) begin
                t0 = $time;
                aborted = 1'b0;
                repeat (BITC / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BITC) @(negedge clk);
                if (!aborted && tx) begin
                    got.push_back(b);
                    lat.push_back(t0 - last_mid);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        rx = stop;
        repeat (BITC / 2) @(negedge clk);
        last_mid = $time;
        repeat (BITC / 2) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic mk(input logic [95:0] v, input int n);
        for (int i = 0; i < n; i++) stim.push_back(v[8*(n-1-i) +: 8]);
    endtask

    // Reference: walk the byte stream packet by packet using the protocol rules
    task automatic model(input logic [7:0] s[$], output logic [7:0] e[$]);
        int i;
        int len;
        logic [7:0] op;
        logic [31:0] a, b, r;
        e = {};
        i = 0;
        while (i < s.size()) begin
            op = s[i];
            i++;
            if (op == 8'hEC || op == 8'hAD || (MUL && op == 8'hAE)) begin
                if (i + 3 > s.size()) break;
                len = s[i+1] + 256 * s[i+2];
                i += 3;
                if (op == 8'hEC) begin
                    for (int k = 4; k < len && i < s.size(); k++) begin
                        e.push_back(s[i]);
                        i++;
                    end
                end else begin
                    if (i + 8 > s.size()) break;
                    a = {s[i+3], s[i+2], s[i+1], s[i]};
                    b = {s[i+7], s[i+6], s[i+5], s[i+4]};
                    i += 8;
                    r = (op == 8'hAD) ? a + b : a * b;
                    for (int k = 0; k < 4; k++) e.push_back(8'(r >> (8 * k)));
                end
            end
        end
    endtask

    task automatic cmp_out(input string tag, input bit chk_lat);
        check({tag, "_count"}, got.size(), exp_q.size());
        foreach (exp_q[i])
            check($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        if (chk_lat)
            foreach (lat[i]) check($sformatf("%s_lat%0d", tag, i), 32'(lat[i] <= 2 * BITC * 10), 32'd1);
    endtask

    task automatic run(input string tag, input bit chk_lat);
        model(stim, exp_q);
        got = {};
        lat = {};
        foreach (stim[i]) send_byte(stim[i]);
        repeat (50 * BITC) @(negedge clk);
        cmp_out(tag, chk_lat);
        stim = {};
    endtask

    initial begin
        logic [7:0] g;
        int len;
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_opa", dut.ua_inst.operand_a_q, 0);
        check("reset_opb", dut.ua_inst.operand_b_q, 0);
        check("reset_len", dut.ua_inst.r_len, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        mk(96'hEC_00_06_00_48_69, 6);
        run("echo", 1'b1);

        mk(96'hEC_00_06_00_48_69, 6);
        model(stim, exp_q);
        got = {};
        lat = {};
        for (int i = 0; i < 5; i++) send_byte(stim[i]);
        repeat (20 * BITC) @(negedge clk);
        send_byte(stim[5]);
        repeat (50 * BITC) @(negedge clk);
        cmp_out("echo_gap", 1'b1);
        stim = {};

        mk(96'h00_48_EC_00_07_00_61_62_63, 9);
        run("echo_garbage", 1'b1);

        mk(96'hAD_00_0D_00_FF_02_4B_0D_21_43_65_87, 12);
        model(stim, exp_q);
        got = {};
        lat = {};
        for (int i = 0; i < 8; i++) send_byte(stim[i]);
        check("add_opa", dut.ua_inst.operand_a_q, 32'h0D4B02FF);
        for (int i = 8; i < 12; i++) send_byte(stim[i]);
        check("add_opb", dut.ua_inst.operand_b_q, 32'h87654321);
        repeat (50 * BITC) @(negedge clk);
        cmp_out("add", 1'b0);
        stim = {};

        mk(96'hAD_00_0C_00_FF_FF_FF_FF_01_00_00_00, 12);
        run("add_wrap", 1'b0);

        got = {};
        lat = {};
        mk(96'hEC_00_07_00_41, 5);
        foreach (stim[i]) send_byte(stim[i]);
        send_byte(8'h42, 1'b0);
        repeat (BITC) @(negedge clk);
        send_byte(8'h43);
        send_byte(8'h44);
        repeat (50 * BITC) @(negedge clk);
        exp_q = {8'h41, 8'h43, 8'h44};
        cmp_out("bad_stop", 1'b1);
        stim = {};

        got = {};
        mk(96'hEC_00_08_00_11_22, 6);
        foreach (stim[i]) send_byte(stim[i]);
        stim = {};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_tx", tx, 1);
        check("midreset_pre_count", got.size(), 1);
        check("midreset_pre_byte", got.size() > 0 ? {24'd0, got[0]} : 32'hFFFF_FFFF, 32'h11);
        repeat (20) @(negedge clk);
        check("midreset_tx_hold", tx, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        mk(96'hEC_00_05_00_5A, 5);
        run("after_reset", 1'b1);

        mk(96'hAE_00_0C_00_03_00_00_00_05_00_00_00, 12);
        run("mul", 1'b0);

        for (int it = 0; it < 8; it++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                g = 8'($urandom);
                while (g == 8'hEC || g == 8'hAD || g == 8'hAE) g = 8'($urandom);
                stim.push_back(g);
            end
            if ($urandom_range(0, 1) == 1) begin
                len = $urandom_range(0, 9);
                stim.push_back(8'hEC);
                stim.push_back(8'($urandom));
                stim.push_back(8'(len));
                stim.push_back(8'h00);
                for (int k = 4; k < len; k++) stim.push_back(8'($urandom));
                run($sformatf("rand_echo%0d", it), 1'b1);
            end else begin
                stim.push_back((MUL && $urandom_range(0, 1) == 1) ? 8'hAE : 8'hAD);
                for (int k = 0; k < 11; k++) stim.push_back(8'($urandom));
                run($sformatf("rand_alu%0d", it), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
